uart_rxd: RTL and testbench

UART receiver for the UART_SDRAM_UART datapath: 8N1, LSB first, idle-high line, 115200 baud from the 20 MHz SYS_CLK (50 ns period). It is the counterpart of the transmit side. Each received byte is presented on `rx_data` with a one-cycle `rx_valid` strobe for the downstream SDRAM write buffer. It reports framing errors and drops false start bits.

---
 rtl/uart_rxd_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rxd.sv | 146 ++++++++++++++
 tb/tb_uart_rxd.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rxd_pkg.sv
// Shared UART definitions: baud constants, receiver state encoding and the
// 2-of-3 majority helper used by the bit sampler.
package uart_rxd_pkg;

   localparam int unsigned BAUD           = 32'd115200;
   localparam int unsigned SYS_CLK_PERIOD = 32'd50;
   // 1e9 ns / 115200 baud / 50 ns = 173 (truncated); one bit is BAUD_CNT_END+1 clocks
   localparam int unsigned BAUD_CNT_END   = 32'd1_000_000_000 / BAUD / SYS_CLK_PERIOD;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector; every stage resets to the idle (high) level so reset never fakes an edge.
module uart_rx_sync (
   input  logic SYS_CLK,
   input  logic RST_N,
   input  logic rxd_i,
   output logic rxd_s,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchronizer chain and one-cycle history of the synchronized line.
   always_ff @(posedge SYS_CLK or negedge RST_N) begin
      if (!RST_N) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= rxd_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rxd_s = sync_q;
   assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rxd.sv
// 8N1 UART receiver: centre-sampled 2-of-3 majority vote per bit, glitch
// rejection on the start bit, framing-error pulse, early return at mid-stop.
module uart_rxd #(
   parameter int unsigned BAUD_CNT_END = uart_rxd_pkg::BAUD_CNT_END,
   parameter int unsigned MID          = BAUD_CNT_END / 32'd2
) (
   input  logic       SYS_CLK,
   input  logic       RST_N,
   input  logic       Rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       frame_err
);

   import uart_rxd_pkg::*;

   localparam logic [15:0] CNT_END       = 16'(BAUD_CNT_END);
   localparam logic [15:0] SMP_LO        = 16'(MID - 32'd1);
   localparam logic [15:0] SMP_MID       = 16'(MID);
   localparam logic [15:0] SMP_HI        = 16'(MID + 32'd1);
   localparam logic [3:0]  LAST_DATA_CNT = 4'd8;

   logic        rxd_sync_s;
   logic        fall_s;
   logic        vote_s;
   logic        at_decide_s;

   rx_state_e   state_q;
   logic [15:0] baud_cnt_q;
   logic [15:0] baud_cnt_d;
   logic [3:0]  bit_cnt_q;
   logic [3:0]  bit_cnt_d;
   logic [7:0]  shift_q;
   logic        smp_lo_q;
   logic        smp_mid_q;
   logic [7:0]  rx_data_q;
   logic        rx_valid_q;
   logic        frame_err_q;
   logic        rx_busy_q;

   uart_rx_sync u_sync (
      .SYS_CLK (SYS_CLK),
      .RST_N   (RST_N),
      .rxd_i   (Rxd),
      .rxd_s   (rxd_sync_s),
      .fall    (fall_s)
   );

   // The third sample is taken live, so the vote is ready in the decision cycle.
   assign vote_s      = maj3(smp_lo_q, smp_mid_q, rxd_sync_s);
   assign at_decide_s = (baud_cnt_q == SMP_HI);

   // Baud and bit counters: held at zero in IDLE, bit_cnt steps on each baud wrap.
   always_comb begin
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      if (state_q == ST_IDLE) begin
         baud_cnt_d = 16'd0;
         bit_cnt_d  = 4'd0;
      end else if (baud_cnt_q == CNT_END) begin
         baud_cnt_d = 16'd0;
         bit_cnt_d  = bit_cnt_q + 4'd1;
      end else begin
         baud_cnt_d = baud_cnt_q + 16'd1;
         bit_cnt_d  = bit_cnt_q;
      end
   end

   // Receive FSM with registered data, strobes and busy flag.
   always_ff @(posedge SYS_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         baud_cnt_q  <= 16'd0;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 8'h00;
         smp_lo_q    <= 1'b1;
         smp_mid_q   <= 1'b1;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         rx_busy_q   <= 1'b0;
      end else begin
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         baud_cnt_q  <= baud_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         if (baud_cnt_q == SMP_LO) begin
            smp_lo_q <= rxd_sync_s;
         end
         if (baud_cnt_q == SMP_MID) begin
            smp_mid_q <= rxd_sync_s;
         end

         case (state_q)
            ST_IDLE: begin
               if (fall_s) begin
                  state_q   <= ST_START;
                  rx_busy_q <= 1'b1;
               end
            end
            ST_START: begin
               if (at_decide_s) begin
                  if (vote_s) begin
                     state_q   <= ST_IDLE;
                     rx_busy_q <= 1'b0;
                  end else begin
                     state_q   <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (at_decide_s) begin
                  // Shifting in from the top leaves the first (LSB) bit in shift_q[0].
                  shift_q <= {vote_s, shift_q[7:1]};
                  if (bit_cnt_q == LAST_DATA_CNT) begin
                     state_q <= ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               if (at_decide_s) begin
                  state_q   <= ST_IDLE;
                  rx_busy_q <= 1'b0;
                  if (vote_s) begin
                     rx_data_q  <= shift_q;
                     rx_valid_q <= 1'b1;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               rx_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign rx_busy   = rx_busy_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rxd.sv
// Self-checking bench for uart_rxd: directed vector table, hand-written
// corner sequences and randomized frames against a frame-level reference model.
module tb_uart_rxd;

   logic       SYS_CLK = 1'b0;
   logic       RST_N;
   logic       Rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;

   uart_rxd dut (
      .SYS_CLK   (SYS_CLK),
      .RST_N     (RST_N),
      .Rxd       (Rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_busy   (rx_busy),
      .frame_err (frame_err)
   );

   always #25 SYS_CLK = ~SYS_CLK;

   int cyc = 0;
   always @(posedge SYS_CLK) cyc <= cyc + 1;

   int         valid_cnt = 0;
   int         ferr_cnt = 0;
   int         both_cnt = 0;
   int         long_cnt = 0;
   int         busy_cycles = 0;
   int         valid_cyc = 0;
   int         busy_rise_cyc = 0;
   int         busy_fall_cyc = 0;
   logic [7:0] cap_data = 8'h00;
   logic       prev_valid = 1'b0;
   logic       prev_ferr = 1'b0;
   logic       prev_busy = 1'b0;

   // Output monitor, sampled on the falling edge.
   always @(negedge SYS_CLK) begin
      if (rx_valid) begin
         valid_cnt <= valid_cnt + 1;
         cap_data  <= rx_data;
         valid_cyc <= cyc;
      end
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (rx_valid && frame_err) both_cnt <= both_cnt + 1;
      if ((rx_valid && prev_valid) || (frame_err && prev_ferr)) long_cnt <= long_cnt + 1;
      if (rx_busy && !prev_busy) busy_rise_cyc <= cyc;
      if (!rx_busy && prev_busy) busy_fall_cyc <= cyc;
      if (rx_busy) busy_cycles <= busy_cycles + 1;
      prev_valid <= rx_valid;
      prev_ferr  <= frame_err;
      prev_busy  <= rx_busy;
   end

   int chk_cnt = 0;
   int pass_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // Called at #1 after a rising edge; leaves the caller at the same phase.
   task automatic drive_bit(input logic v, input int per);
      Rxd = v;
      repeat (per) @(posedge SYS_CLK);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input int per, input logic stop, output int c0);
      c0 = cyc;
      drive_bit(1'b0, per);
      for (int i = 0; i < 8; i++) drive_bit(b[i], per);
      drive_bit(stop, per);
   endtask

   task automatic run_frame(input string tag, input logic [7:0] b, input int per, input logic stop,
                            input int gap, input logic [7:0] exp_data, input int exp_valid,
                            input int exp_ferr);
      int v0, f0, c0;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(b, per, stop, c0);
      if (gap > 0) drive_bit(1'b1, gap);
      check({tag, "_valid"}, valid_cnt - v0, exp_valid);
      check({tag, "_ferr"}, ferr_cnt - f0, exp_ferr);
      check({tag, "_data"}, int'(rx_data), int'(exp_data));
   endtask

   typedef struct {
      logic [7:0] data;
      int         per;
      logic       stop;
      int         gap;
      logic [7:0] exp_data;
      int         exp_valid;
      int         exp_ferr;
   } vec_t;

   vec_t       vecs[7];
   logic [7:0] last_good;

   initial begin
      int c0, v0, f0, b0;
      vecs[0] = '{8'hA3, 174, 1'b1,  0, 8'hA3, 1, 0};
      vecs[1] = '{8'h00, 174, 1'b1,  0, 8'h00, 1, 0};
      vecs[2] = '{8'hFF, 174, 1'b1, 20, 8'hFF, 1, 0};
      vecs[3] = '{8'hC6, 167, 1'b1, 20, 8'hC6, 1, 0};
      vecs[4] = '{8'hC6, 181, 1'b1, 20, 8'hC6, 1, 0};
      vecs[5] = '{8'h3C, 174, 1'b0, 20, 8'hC6, 0, 1};
      vecs[6] = '{8'h81, 174, 1'b1, 20, 8'h81, 1, 0};

      Rxd   = 1'b1;
      RST_N = 1'b0;
      repeat (3) @(posedge SYS_CLK);
      #1;
      check("rst_data", int'(rx_data), 0);
      check("rst_valid", int'(rx_valid), 0);
      check("rst_ferr", int'(frame_err), 0);
      check("rst_busy", int'(rx_busy), 0);
      RST_N = 1'b1;
      repeat (5) @(posedge SYS_CLK);
      #1;

      // Exact-rate 0x55 with strobe and busy timing relative to the start edge.
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(8'h55, 174, 1'b1, c0);
      drive_bit(1'b1, 20);
      check("b55_valid", valid_cnt - v0, 1);
      check("b55_ferr", ferr_cnt - f0, 0);
      check("b55_data", int'(rx_data), 8'h55);
      check("b55_valid_cycle", valid_cyc - c0, 1657);
      check("b55_busy_rise", busy_rise_cyc - c0, 3);
      check("b55_busy_fall", busy_fall_cyc - c0, 1657);

      for (int i = 0; i < 7; i++) begin
         run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].per, vecs[i].stop, vecs[i].gap,
                   vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_ferr);
      end
      last_good = 8'h81;

      // Short low glitch: start vote rejects it after 88 busy cycles.
      v0 = valid_cnt;
      f0 = ferr_cnt;
      b0 = busy_cycles;
      drive_bit(1'b0, 40);
      drive_bit(1'b1, 300);
      check("glitch_busy_cycles", busy_cycles - b0, 88);
      check("glitch_valid", valid_cnt - v0, 0);
      check("glitch_ferr", ferr_cnt - f0, 0);

      // Line held low: a single framing error, no retrigger.
      v0 = valid_cnt;
      f0 = ferr_cnt;
      drive_bit(1'b0, 3000);
      check("break_ferr", ferr_cnt - f0, 1);
      check("break_valid", valid_cnt - v0, 0);
      check("break_busy", int'(rx_busy), 0);
      drive_bit(1'b1, 200);
      check("break_data", int'(rx_data), int'(last_good));

      // Reset asserted during data bit 4 of 0x5A.
      drive_bit(1'b0, 174);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] pat;
         pat = 8'h5A;
         drive_bit(pat[i], 174);
      end
      Rxd = 1'b1;
      repeat (80) @(posedge SYS_CLK);
      #1;
      check("midrst_busy_before", int'(rx_busy), 1);
      #10 RST_N = 1'b0;
      #1;
      check("midrst_data", int'(rx_data), 0);
      check("midrst_valid", int'(rx_valid), 0);
      check("midrst_ferr", int'(frame_err), 0);
      check("midrst_busy", int'(rx_busy), 0);
      repeat (5) @(posedge SYS_CLK);
      #1;
      RST_N = 1'b1;
      drive_bit(1'b1, 300);
      last_good = 8'h00;
      check("postrst_data", int'(rx_data), int'(last_good));
      run_frame("postrst_12", 8'h12, 174, 1'b1, 20, 8'h12, 1, 0);
      last_good = 8'h12;

      // Randomized frames against the frame-level model.
      for (int n = 0; n < 20; n++) begin
         logic [7:0] b;
         logic       stop;
         int         per, gap;
         b    = 8'($urandom);
         per  = int'($urandom_range(168, 180));
         stop = ($urandom_range(0, 4) != 0);
         gap  = stop ? int'($urandom_range(0, 30)) : int'($urandom_range(4, 30));
         if (stop) last_good = b;
         run_frame($sformatf("rnd%0d", n), b, per, stop, gap, last_good, stop ? 1 : 0, stop ? 0 : 1);
      end
      drive_bit(1'b1, 50);

      check("strobes_exclusive", both_cnt, 0);
      check("strobes_one_cycle", long_cnt, 0);
      check("end_idle", int'(rx_busy), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
